// File: rtl/des_pkg.sv
// Shared DES controller constants, state encoding, permutation tables and 28-bit rotate helpers.
// Bit numbering follows DES: bit 1 is the MSB of each [N:1] vector.
package des_pkg;

  localparam logic [4:0] DES_ROUNDS = 5'd16;

  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned IPINV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Shift amount for a 1-based round number.
  function automatic logic [1:0] shift_of(input logic [4:0] rnd);
    logic [3:0] k;
    k = 4'(rnd - 5'd1);
    return SHIFT[k];
  endfunction

  function automatic logic [28:1] rol28(input logic [28:1] x, input logic [1:0] n);
    case (n)
      2'd1:    rol28 = {x[27:1], x[28]};
      2'd2:    rol28 = {x[26:1], x[28:27]};
      default: rol28 = x;
    endcase
  endfunction

  function automatic logic [28:1] ror28(input logic [28:1] x, input logic [1:0] n);
    case (n)
      2'd1:    ror28 = {x[1], x[28:2]};
      2'd2:    ror28 = {x[2:1], x[28:3]};
      default: ror28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_ip.sv
// DES initial permutation.
module des_ip
  import des_pkg::*;
(
  input  logic [64:1] din,
  output logic [64:1] dout
);
  for (genvar j = 1; j <= 64; j++) begin : g_bit
    assign dout[65-j] = din[65-IP_T[j-1]];
  end
endmodule

// File: rtl/des_ip_inv.sv
// DES inverse initial permutation.
module des_ip_inv
  import des_pkg::*;
(
  input  logic [64:1] din,
  output logic [64:1] dout
);
  for (genvar j = 1; j <= 64; j++) begin : g_bit
    assign dout[65-j] = din[65-IPINV_T[j-1]];
  end
endmodule

// File: rtl/des_key_sched.sv
// DES key schedule: C/D registers, per-round rotate (left for encrypt, right for decrypt), PC-2.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        decrypt,
  input  logic [4:0]  round,
  input  logic [56:1] cd_init,
  output logic [48:1] subkey
);
  logic [28:1] c_q, d_q, c_rot, d_rot;
  logic [56:1] pc2_in;
  logic [1:0]  sh;

  // Encrypt rotates before PC-2; decrypt uses C/D as-is and rotates back afterwards.
  always_comb begin
    sh     = decrypt ? shift_of(5'd17 - round) : shift_of(round);
    c_rot  = decrypt ? ror28(c_q, sh) : rol28(c_q, sh);
    d_rot  = decrypt ? ror28(d_q, sh) : rol28(d_q, sh);
    pc2_in = decrypt ? {c_q, d_q} : {c_rot, d_rot};
  end

  des_pc2 u_pc2 (
    .din  (pc2_in),
    .dout (subkey)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
    end else if (load) begin
      c_q <= cd_init[56:29];
      d_q <= cd_init[28:1];
    end else if (step) begin
      c_q <= c_rot;
      d_q <= d_rot;
    end
  end
endmodule

// File: rtl/des_pc1.sv
// DES permuted choice 1: 64-bit key to 56-bit C||D; parity bits are discarded.
module des_pc1
  import des_pkg::*;
(
  input  logic [64:1] din,
  output logic [56:1] dout
);
  logic unused_parity;

  for (genvar j = 1; j <= 56; j++) begin : g_bit
    assign dout[57-j] = din[65-PC1_T[j-1]];
  end

  assign unused_parity = ^{din[57], din[49], din[41], din[33], din[25], din[17], din[9], din[1]};
endmodule

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [56:1] din,
  output logic [48:1] dout
);
  logic unused_dropped;

  for (genvar j = 1; j <= 48; j++) begin : g_bit
    assign dout[49-j] = din[57-PC2_T[j-1]];
  end

  // DES bits 9,18,22,25,35,38,43,54 are not selected by PC-2.
  assign unused_dropped = ^{din[48], din[39], din[35], din[32], din[22], din[19], din[14], din[3]};
endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES controller: IP, 16 Feistel rounds (external f-function), final swap and IP-inverse.
// Optional macro DES_KEY_PARITY_CHECK_EN adds a registered key_parity_err output.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [64:1] data_in,
  input  logic [64:1] key_in,
  output logic [32:1] f_r,
  output logic [48:1] f_subkey,
  input  logic [32:1] f_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [64:1] data_out,
  output logic [4:0]  round_idx
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        key_parity_err
`endif
);
  state_t      state, state_nxt;
  logic [32:1] l_q, r_q, l_nxt, r_nxt;
  logic [64:1] ip_out, ipinv_out, data_q;
  logic [56:1] pc1_out;
  logic [48:1] subkey;
  logic [4:0]  round_q;
  logic        dec_q, ov_q, accept, last_round, in_round;

  des_ip u_ip (
    .din  (data_in),
    .dout (ip_out)
  );

  des_pc1 u_pc1 (
    .din  (key_in),
    .dout (pc1_out)
  );

  // Final swap folded in: IP-inverse sees R16||L16 from the next-state values.
  des_ip_inv u_ipinv (
    .din  ({r_nxt, l_nxt}),
    .dout (ipinv_out)
  );

  des_key_sched u_ks (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (in_round),
    .decrypt (dec_q),
    .round   (round_q),
    .cd_init (pc1_out),
    .subkey  (subkey)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_round = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (round_q == DES_ROUNDS) begin
          last_round = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    in_round = (state == ROUND);
    l_nxt    = r_q;
    r_nxt    = l_q ^ f_result;
    f_r      = in_round ? r_q : '0;
    f_subkey = in_round ? subkey : '0;
  end

  assign out_valid = ov_q;
  assign data_out  = data_q;
  assign round_idx = round_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      dec_q   <= 1'b0;
      round_q <= '0;
      data_q  <= '0;
      ov_q    <= 1'b0;
    end else if (accept) begin
      {l_q, r_q} <= ip_out;
      dec_q      <= decrypt;
      round_q    <= 5'd1;
    end else if (in_round) begin
      l_q <= l_nxt;
      r_q <= r_nxt;
      if (last_round) begin
        data_q  <= ipinv_out;
        ov_q    <= 1'b1;
        round_q <= '0;
      end else begin
        round_q <= round_q + 5'd1;
      end
    end else if (state == DONE && out_ready) begin
      ov_q <= 1'b0;
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_bad;

  // Each key byte must have odd parity; the flag never stalls processing.
  always_comb begin
    par_bad = 1'b0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (!(^key_in[b*8+1 +: 8])) par_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         key_parity_err <= 1'b0;
    else if (accept) key_parity_err <= par_bad;
  end
`endif

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Iterative DES engine controller. Sequences one 64-bit block through IP, 16 Feistel rounds (one per clock) and the inverse initial permutation.
- Owns the L/R round registers, the C/D key-schedule registers, and the round FSM.
- The Feistel f-function (expansion, S-boxes, P) sits outside this block and is driven combinationally through an f-port.
- The existing IP, IP-inverse, PC-1 and PC-2 permutation modules are instantiated inside.
- Bit numbering follows DES convention: [N:1], bit 1 = MSB.

Parameters:
- None. Round count (16) and shift schedule are fixed constants in the package.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  block/key offered
- in_ready  output  1  controller can accept a block (high only in IDLE)
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept
- data_in  input  64 [64:1]  plaintext/ciphertext
- key_in  input  64 [64:1]  DES key including parity bits
- f_r  output  32 [32:1]  current R to external f-function
- f_subkey  output  48 [48:1]  current round subkey PC2(C||D)
- f_result  input  32 [32:1]  f(f_r, f_subkey), combinational return
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- data_out  output  64 [64:1]  result block
- round_idx  output  5  current round 1..16; 0 outside ROUND

Behaviour:
- Reset (asynchronous, any state including mid-round):
  - state = IDLE; L, R, C, D, data_out = 0; out_valid = 0; round_idx = 0.
  - in_ready is 1 after reset release.
- FSM states: IDLE -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: {L,R} <= IP(data_in); {C,D} <= PC1(key_in); latch decrypt; round_idx <= 1; go to ROUND.
- ROUND, with i = round_idx:
  - Encrypt: CDn = ROL28 of C and D by SHIFT[i]; f_subkey = PC2(CDn); {C,D} <= CDn.
  - Decrypt: f_subkey = PC2(C,D) with no pre-shift, so round 1 uses K16; then {C,D} <= ROR28 by SHIFT[17-i].
  - Every round: f_r = R; L <= R; R <= L ^ f_result.
  - At i = 16: data_out <= IPinv(R_next || L_next) (final swap), out_valid <= 1, round_idx <= 0, go to DONE. Otherwise round_idx <= i+1.
- DONE:
  - data_out and out_valid are held stable until out_ready = 1, then out_valid <= 0 and go to IDLE.
  - in_ready = 0 in DONE, so there is no overlap.
- SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. The sum is 28, so C/D return to PC1(key) after 16 rounds in either direction.
- Latency: the accept edge is cycle 0; out_valid rises at the cycle-16 edge. Throughput is one block per 18 cycles minimum (accept, 16 rounds, DONE handshake).
- f_r and f_subkey are don't-care outside ROUND; drive 0 for lint and waveform clarity.
- in_valid while busy is ignored. Inputs are sampled only on accept, so data_in, key_in and decrypt may change freely afterwards.
- out_ready while out_valid = 0 has no effect.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- When defined:
  - Extra output key_parity_err (1 bit), registered at accept.
  - It is 1 if any key_in byte lacks odd parity (bits 8,16,...,64 are the parity bits).
  - It is held with data_out through DONE and cleared by reset or the next accept.
  - Processing is not blocked.
- When undefined: the port and logic are absent; parity bits are ignored, as PC-1 drops them.

Decomposition:
- Package des_pkg holds:
  - constants DES_ROUNDS = 16 and the SHIFT table;
  - state enum {IDLE, ROUND, DONE};
  - 28-bit rotate-left and rotate-right functions.
- Sub-module des_key_sched holds the C/D registers, the rotate-direction mux and the PC-2 instance, and outputs the subkey.
- IP, IP-inverse and PC-1 are instantiated in des_round_ctrl. The f-function stays external.

Test Plan:
- Encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF -> data_out 85E813540F0AB405; out_valid rises 16 cycles after accept.
- Decrypt, same key, data 85E813540F0AB405 -> 0123456789ABCDEF. Also check f_subkey in round 1 equals the encrypt round-16 subkey.
- Encrypt, key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000. Hold out_ready = 0 for 5 cycles: data_out stable, in_ready = 0, a second in_valid is ignored.
- Assert rst at round 7 -> out_valid = 0, in_ready = 1 and round_idx = 0 immediately. The following encrypt of vector 1 gives the correct result.
- Back-to-back: out_ready tied 1 with in_valid held -> accepts 18 cycles apart; round_idx steps 1..16 in each block.
- With DES_KEY_PARITY_CHECK_EN defined:
  - key 133457799BBCDFF1 -> key_parity_err = 0.
  - key 123457799BBCDFF1 -> key_parity_err = 1, with ciphertext identical to vector 1.
